// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory access controller (IDLE/BUSY/DONE handshake, big-endian lanes, timeout)
//   clk, reset (async, active-high); CPU side: MemRead, MemWrite, MemSize, MemSigned, Addr, WriteData
//   -> ReadData, Stall, AddrError, BusError; memory side: mem_req, mem_we, mem_addr, mem_be, mem_wdata
//   <- mem_rdata, mem_ack
module dmem_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemSigned,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        AddrError,
  output logic        BusError,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  logic [1:0]  state_q, state_d, size_q, size_d, off_q, off_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        sign_q, sign_d, we_q, we_d, bus_err_q, bus_err_d;
  logic [29:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d, lane_sh, ext;
  logic        idle, busy, is_req, mis, accept, tmo;
  always_comb begin
    idle      = state_q == IDLE;
    busy      = state_q == BUSY;
    is_req    = MemRead | MemWrite;
    mis       = (MemSize == 2'b11) | (MemRead & MemWrite) | ((MemSize == 2'b00) & (|Addr[1:0])) | ((MemSize == 2'b01) & Addr[0]);
    accept    = idle & is_req & ~mis;
    tmo       = busy & ~mem_ack & (cnt_q == 8'(TIMEOUT - 1));
    // shifting the addressed lane to the top makes byte/half extraction offset-independent
    lane_sh   = mem_rdata << {off_q, 3'b000};
    ext       = size_q == 2'b10 ? {{24{sign_q & lane_sh[31]}}, lane_sh[31:24]} :
                size_q == 2'b01 ? {{16{sign_q & lane_sh[31]}}, lane_sh[31:16]} : mem_rdata;
    state_d   = accept ? BUSY : busy ? ((mem_ack | tmo) ? DONE : BUSY) : IDLE;
    cnt_d     = accept ? 8'd0 : busy ? cnt_q + 8'd1 : cnt_q;
    rdata_d   = tmo ? 32'd0 : (busy & mem_ack & ~we_q) ? ext : rdata_q;
    bus_err_d = tmo;
    we_d      = accept ? MemWrite : we_q;
    addr_d    = accept ? Addr[31:2] : addr_q;
    size_d    = accept ? MemSize : size_q;
    off_d     = accept ? Addr[1:0] : off_q;
    sign_d    = accept ? MemSigned : sign_q;
    be_d      = !accept ? be_q : MemSize == 2'b00 ? 4'b1111 :
                MemSize == 2'b01 ? (Addr[1] ? 4'b0011 : 4'b1100) : 4'b1000 >> Addr[1:0];
    wdata_d   = !accept ? wdata_q : MemSize == 2'b10 ? {4{WriteData[7:0]}} :
                MemSize == 2'b01 ? {2{WriteData[15:0]}} : WriteData;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      off_q     <= '0;
      sign_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      size_q    <= size_d;
      off_q     <= off_d;
      sign_q    <= sign_d;
    end
  end
  assign mem_req   = busy;
  assign Stall     = accept | busy;
  assign AddrError = idle & is_req & mis;
  assign BusError  = bus_err_q;
  assign ReadData  = rdata_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed self-checking bench for dmem_ctrl
module tb_dmem_ctrl;
  logic        clk = 1'b0, reset = 1'b1;
  logic        MemRead = 1'b0, MemWrite = 1'b0, MemSigned = 1'b0, mem_ack = 1'b0;
  logic [1:0]  MemSize = 2'b00;
  logic [31:0] Addr = '0, WriteData = '0, mem_rdata = '0;
  logic [31:0] ReadData, mem_wdata;
  logic        Stall, AddrError, BusError, mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  int total = 0, bad = 0, n;
  dmem_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize),
    .MemSigned(MemSigned), .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData),
    .Stall(Stall), .AddrError(AddrError), .BusError(BusError), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );
  initial forever #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // issues one request just after a rising edge, acks on BUSY cycle ack_at (never if <0),
  // returns the number of stalled cycles and leaves the bench in the DONE cycle
  task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                        input int ack_at, output int cnt);
    MemRead = rd; MemWrite = wr; MemSize = sz; MemSigned = sg; Addr = a; WriteData = wd;
    mem_rdata = rdat; cnt = 0;
    #1;
    while (Stall && cnt < 40) begin
      mem_ack = (cnt == ack_at);
      @(posedge clk); #1;
      mem_ack = 1'b0; cnt++;
      #1;
    end
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask
  task automatic next_cycle();
    @(posedge clk); #2;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_stall", 32'(Stall), 32'd0);
    chk("rst_rdata", ReadData, 32'd0);
    chk("rst_buserr", 32'(BusError), 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    access(1, 0, 2'b00, 0, 32'h100, 32'h0, 32'hDEADBEEF, 3, n);
    chk("wl_stall_cycles", 32'(n), 32'd4);
    chk("wl_rdata", ReadData, 32'hDEADBEEF);
    chk("wl_addr", 32'(mem_addr), 32'h40);
    chk("wl_be", 32'(mem_be), 32'hF);
    chk("wl_done_req", 32'(mem_req), 32'd0);
    next_cycle();
    MemRead = 1'b1; MemSize = 2'b00; Addr = 32'h200; mem_rdata = 32'h55555555;
    #1;
    chk("rb_accept_stall", 32'(Stall), 32'd1);
    @(posedge clk); #1;
    chk("rb_busy1_req", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    mem_ack = 1'b1; reset = 1'b1; MemRead = 1'b0;
    #1;
    chk("rb_req", 32'(mem_req), 32'd0);
    chk("rb_stall", 32'(Stall), 32'd0);
    chk("rb_rdata", ReadData, 32'd0);
    chk("rb_addr", 32'(mem_addr), 32'd0);
    #1 mem_ack = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
    chk("rb_idle_req", 32'(mem_req), 32'd0);
    access(1, 0, 2'b10, 1, 32'h203, 32'h0, 32'h112233F4, 1, n);
    chk("bs_stall_cycles", 32'(n), 32'd2);
    chk("bs_rdata", ReadData, 32'hFFFFFFF4);
    chk("bs_be", 32'(mem_be), 32'h1);
    chk("bs_addr", 32'(mem_addr), 32'h80);
    next_cycle();
    access(1, 0, 2'b10, 0, 32'h203, 32'h0, 32'h112233F4, 2, n);
    chk("bu_rdata", ReadData, 32'h000000F4);
    next_cycle();
    access(1, 0, 2'b10, 1, 32'h201, 32'h0, 32'h11A233F4, 1, n);
    chk("b1_rdata", ReadData, 32'hFFFFFFA2);
    chk("b1_be", 32'(mem_be), 32'h4);
    next_cycle();
    access(1, 0, 2'b01, 1, 32'h100, 32'h0, 32'h80011234, 1, n);
    chk("hl_rdata", ReadData, 32'hFFFF8001);
    chk("hl_be", 32'(mem_be), 32'hC);
    next_cycle();
    access(0, 1, 2'b01, 0, 32'h102, 32'h0000ABCD, 32'h12345678, 1, n);
    chk("hs_we", 32'(mem_we), 32'd1);
    chk("hs_be", 32'(mem_be), 32'h3);
    chk("hs_wdata", mem_wdata, 32'hABCDABCD);
    chk("hs_addr", 32'(mem_addr), 32'h40);
    chk("hs_rdata_kept", ReadData, 32'hFFFF8001);
    next_cycle();
    access(0, 1, 2'b10, 0, 32'h302, 32'h000000C3, 32'h0, 1, n);
    chk("bst_wdata", mem_wdata, 32'hC3C3C3C3);
    chk("bst_be", 32'(mem_be), 32'h2);
    next_cycle();
    MemRead = 1'b1; MemSize = 2'b00; Addr = 32'h6;
    #1;
    chk("mis_err", 32'(AddrError), 32'd1);
    chk("mis_stall", 32'(Stall), 32'd0);
    @(posedge clk); #1;
    chk("mis_req", 32'(mem_req), 32'd0);
    MemSize = 2'b01; Addr = 32'h101;
    #1 chk("mis_half_err", 32'(AddrError), 32'd1);
    MemSize = 2'b11; Addr = 32'h100;
    #1 chk("mis_size3_err", 32'(AddrError), 32'd1);
    MemSize = 2'b00; MemWrite = 1'b1;
    #1 chk("mis_both_err", 32'(AddrError), 32'd1);
    MemRead = 1'b0; MemWrite = 1'b0;
    #1 chk("noreq_err", 32'(AddrError), 32'd0);
    @(posedge clk); #1;
    chk("mis_after_req", 32'(mem_req), 32'd0);
    access(1, 0, 2'b00, 0, 32'h10, 32'h0, 32'h12345678, -1, n);
    chk("to_stall_cycles", 32'(n), 32'd17);
    chk("to_buserr", 32'(BusError), 32'd1);
    chk("to_rdata", ReadData, 32'd0);
    chk("to_done_req", 32'(mem_req), 32'd0);
    next_cycle();
    chk("to_idle_buserr", 32'(BusError), 32'd0);
    chk("to_idle_stall", 32'(Stall), 32'd0);
    access(1, 0, 2'b00, 0, 32'h20, 32'h0, 32'hCAFEF00D, 1, n);
    chk("post_to_rdata", ReadData, 32'hCAFEF00D);
    chk("post_to_buserr", 32'(BusError), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the number of BUSY cycles without mem_ack before the access is aborted (legal range 2..255).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port MemRead  input  1  load request from control unit.
REQ-005 SHALL have port MemWrite  input  1  store request from control unit.
REQ-006 SHALL have port MemSize  input  2  access size: 00 word, 01 halfword, 10 byte, 11 illegal.
REQ-007 SHALL have port MemSigned  input  1  1 means sign-extend loads, 0 means zero-extend loads.
REQ-008 SHALL have port Addr  input  32  byte address (datapath ALUResult).
REQ-009 SHALL have port WriteData  input  32  store data (datapath datatwo); low bits hold the byte or halfword.
REQ-010 SHALL have port ReadData  output  32  extended load result returned to the datapath.
REQ-011 SHALL have port Stall  output  1  freezes the PC and register writeback while high.
REQ-012 SHALL have port AddrError  output  1  misaligned or illegal access flag.
REQ-013 SHALL have port BusError  output  1  timeout flag.
REQ-014 SHALL have memory-side outputs mem_req (1), mem_we (1), mem_addr (30, word address = Addr[31:2]), mem_be (4), and mem_wdata (32).
REQ-015 SHALL have memory-side inputs mem_rdata (32) and mem_ack (1).

Function
REQ-016 SHALL implement a three-state FSM with states IDLE, BUSY and DONE.
REQ-017 SHALL, in IDLE, accept a request when exactly one of MemRead or MemWrite is high and the access is aligned.
- Accepting a request registers mem_we, mem_addr, mem_be and mem_wdata, and moves the FSM to BUSY.
REQ-018 SHALL treat an access as misaligned in any of these cases:
- halfword with Addr[0]=1;
- word with Addr[1:0]≠00;
- MemSize=11;
- MemRead and MemWrite both high.
REQ-019 SHALL, for a misaligned access in IDLE, drive AddrError=1 combinationally, issue no memory request, keep Stall=0, and stay in IDLE.
REQ-020 SHALL drive Stall combinationally as (IDLE and request accepted) OR BUSY; Stall SHALL be 0 in DONE.
REQ-021 SHALL hold mem_req=1 throughout BUSY and keep mem_addr, mem_be, mem_wdata and mem_we stable while mem_req=1.
REQ-022 SHALL complete the handshake on any BUSY cycle where mem_ack=1.
- The FSM moves to DONE, mem_req falls on the next cycle, and load data is captured on that edge.
- mem_ack SHALL be ignored outside BUSY.
REQ-023 SHALL use big-endian byte lanes: byte offset 00 maps to bits [31:24] and offset 11 maps to bits [7:0].
REQ-024 SHALL generate mem_be as follows:
- word: 1111;
- halfword at offset 00: 1100; at offset 10: 0011;
- byte: one-hot per REQ-023 (offset 00 gives 1000).
REQ-025 SHALL form store data by replication: byte gives {4{WriteData[7:0]}}, halfword gives {2{WriteData[15:0]}}, word passes WriteData through.
REQ-026 SHALL extract the addressed lane of mem_rdata for loads and extend it to 32 bits according to MemSigned; stores SHALL leave the ReadData register unchanged.
REQ-027 SHALL drive ReadData from the registered load result at all times; the value is valid in DONE.
REQ-028 SHALL run a BUSY cycle counter that is cleared on entry to BUSY.
- If TIMEOUT cycles elapse without mem_ack, the FSM moves to DONE, the ReadData register loads 0, and BusError=1 during DONE only.
REQ-029 SHALL move unconditionally from DONE to IDLE; request inputs seen in DONE belong to the completing instruction and SHALL be ignored.
REQ-030 SHALL give this minimum latency: accept at cycle T, mem_req high from T+1, ack at earliest T+1, DONE at T+2; the instruction therefore occupies at least 3 cycles.

Reset
REQ-031 SHALL, on reset assertion and regardless of clk or current state, force:
- FSM to IDLE and counter to 0;
- mem_req=0, mem_we=0, mem_be=0000, mem_addr=0, mem_wdata=0;
- ReadData=0, BusError=0.
REQ-032 SHALL, when reset asserts during BUSY, drop mem_req immediately and discard any mem_ack still pending.
REQ-033 SHALL begin accepting requests on the first rising clk edge after reset deasserts.

Verification
REQ-034 Word load: Addr=0x00000100, ack 3 cycles after accept, mem_rdata=0xDEADBEEF -> mem_addr=0x40, mem_be=1111, Stall high for 4 cycles, ReadData=0xDEADBEEF in DONE.
REQ-035 Byte loads: Addr=0x203, mem_rdata=0x112233F4 -> ReadData=0xFFFFFFF4 with MemSigned=1 and 0x000000F4 with MemSigned=0.
REQ-036 Halfword store: Addr=0x102, WriteData=0x0000ABCD -> mem_we=1, mem_be=0011, mem_wdata=0xABCDABCD, mem_addr=0x40, ReadData unchanged.
REQ-037 Misaligned word load at Addr=0x6 -> AddrError=1 in the same cycle, mem_req never asserts, Stall=0.
REQ-038 Timeout: mem_ack held 0 with TIMEOUT=16 -> after 16 BUSY cycles, DONE with BusError=1 for one cycle and ReadData=0, then IDLE.
REQ-039 Reset on the 2nd BUSY cycle -> mem_req=0, Stall=0 and ReadData=0 immediately; a following load completes normally.
